// File: rtl/id_stage.sv
// Decode stage: register file, immediate generation and operand select into a one-entry ID/EX register.
// Result appears the cycle after capture. ID_ready = !ID_valid || EX_ready; writeback bypasses and patches a held entry.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_instr,
  input  logic        IF_valid,
  output logic        ID_ready,
  input  logic        EX_ready,
  input  logic        flush,
  input  logic        WB_we,
  input  logic [4:0]  WB_rd,
  input  logic [31:0] WB_val,
  output logic        ID_valid,
  output logic [6:0]  ID_opcode,
  output logic [2:0]  ID_fn_3,
  output logic [6:0]  ID_fn_7,
  output logic [31:0] ID_rs1_val,
  output logic [31:0] ID_mux_val,
  output logic [4:0]  ID_rd,
  output logic        ID_illegal,
  output logic [31:0] ID_issue_cnt
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  logic [31:0] rf [32];

  logic [4:0]  held_rs1;
  logic [4:0]  held_rs2;

  logic [6:0]  opcode;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic        wb_hit;
  logic        accept;
  logic [31:0] rs1_rd;
  logic [31:0] rs2_rd;
  logic [31:0] mux_nxt;
  logic [6:0]  fn7_nxt;
  logic        illegal_nxt;

  assign opcode  = IF_instr[6:0];
  assign rs1_idx = IF_instr[19:15];
  assign rs2_idx = IF_instr[24:20];
  assign wb_hit  = WB_we && (WB_rd != 5'd0);

  // Only depends on entry state and EX_ready, never on IF_valid or WB_*.
  assign ID_ready = !ID_valid || EX_ready;
  assign accept   = IF_valid && ID_ready && !flush;

  always_comb begin
    rs1_rd      = '0;
    rs2_rd      = '0;
    mux_nxt     = '0;
    fn7_nxt     = '0;
    illegal_nxt = 1'b1;

    if (rs1_idx != 5'd0)
      rs1_rd = (wb_hit && WB_rd == rs1_idx) ? WB_val : rf[rs1_idx];
    if (rs2_idx != 5'd0)
      rs2_rd = (wb_hit && WB_rd == rs2_idx) ? WB_val : rf[rs2_idx];

    case (opcode)
      OP_R: begin
        mux_nxt     = rs2_rd;
        fn7_nxt     = IF_instr[31:25];
        illegal_nxt = 1'b0;
      end
      OP_I: begin
        mux_nxt     = {{20{IF_instr[31]}}, IF_instr[31:20]};
        fn7_nxt     = IF_instr[31:25];
        illegal_nxt = 1'b0;
      end
      OP_LOAD: begin
        mux_nxt     = {{20{IF_instr[31]}}, IF_instr[31:20]};
        illegal_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      ID_valid     <= 1'b0;
      ID_opcode    <= '0;
      ID_fn_3      <= '0;
      ID_fn_7      <= '0;
      ID_rs1_val   <= '0;
      ID_mux_val   <= '0;
      ID_rd        <= '0;
      ID_illegal   <= 1'b0;
      ID_issue_cnt <= '0;
      held_rs1     <= '0;
      held_rs2     <= '0;
    end else begin
      if (wb_hit) rf[WB_rd] <= WB_val;
      if (ID_valid && EX_ready) ID_issue_cnt <= ID_issue_cnt + 32'd1;

      if (flush) begin
        ID_valid <= 1'b0;
      end else if (accept) begin
        ID_valid   <= 1'b1;
        ID_opcode  <= opcode;
        ID_fn_3    <= IF_instr[14:12];
        ID_fn_7    <= fn7_nxt;
        ID_rs1_val <= rs1_rd;
        ID_mux_val <= mux_nxt;
        ID_rd      <= IF_instr[11:7];
        ID_illegal <= illegal_nxt;
        held_rs1   <= rs1_idx;
        held_rs2   <= rs2_idx;
      end else if (EX_ready) begin
        ID_valid <= 1'b0;
      end else if (ID_valid && wb_hit) begin
        // Stalled entry: late writeback patches operands already read.
        if (WB_rd == held_rs1)
          ID_rs1_val <= WB_val;
        if (ID_opcode == OP_R && WB_rd == held_rs2)
          ID_mux_val <= WB_val;
      end
    end
  end

endmodule
